// File: rtl/matmul_seq_ctrl_if.sv
// Bundle between the matmul sequencer and its memory port, datapath and start/busy/done controller.
// master = sequencer side, slave = environment side.
interface matmul_seq_ctrl_if #(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEMENTS = 4,
  parameter int ADDR_W       = 16
);
  localparam int DW = NUM_ELEMENTS * WIDTH;

  logic              start;
  logic [ADDR_W-1:0] src_base;
  logic [ADDR_W-1:0] dst_base;
  logic              busy;
  logic              done;

  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic              mem_rd_valid;
  logic [DW-1:0]     mem_rd_data;

  logic              mm_read_en;
  logic [DW-1:0]     mm_rdata;
  logic              mm_write_en;
  logic [DW-1:0]     mm_res;

  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [DW-1:0]     mem_wr_data;
  logic              mem_wr_ack;

  modport master (
    input  start, src_base, dst_base, mem_rd_valid, mem_rd_data, mm_res, mem_wr_ack,
    output busy, done, mem_rd_en, mem_rd_addr, mm_read_en, mm_rdata, mm_write_en,
           mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    output start, src_base, dst_base, mem_rd_valid, mem_rd_data, mm_res, mem_wr_ack,
    input  busy, done, mem_rd_en, mem_rd_addr, mm_read_en, mm_rdata, mm_write_en,
           mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Sequencer: loads operand beats from memory into the matmul datapath, waits out the multiply, writes result columns back.
// Optional perf_cycles/stall_cycles counters are built when MATMUL_SEQ_PERF_CNT_EN is defined.
module matmul_seq_ctrl #(
  parameter int WIDTH        = 8,
  parameter int NUM_ELEMENTS = 4,
  parameter int MATRIX_WIDTH = 4,
  parameter int ADDR_W       = 16,
  parameter int MULT_LATENCY = 4
) (
  input  logic              clk,
  input  logic              reset,
  matmul_seq_ctrl_if.master io_seq
`ifdef MATMUL_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles,
  output logic [31:0]       stall_cycles
`endif
);
  localparam int DW         = NUM_ELEMENTS * WIDTH;
  localparam int LOAD_BEATS = MATRIX_WIDTH * MATRIX_WIDTH / 2;
  localparam int BEAT_W     = (LOAD_BEATS > 1) ? $clog2(LOAD_BEATS) : 1;
  localparam int COL_W      = (MATRIX_WIDTH > 1) ? $clog2(MATRIX_WIDTH) : 1;
  localparam int CNT_W      = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_COMPUTE, S_FETCH, S_CAPTURE, S_WR, S_DONE
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [BEAT_W-1:0] r_beat;
  logic [COL_W-1:0]  r_col;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_mm_rd_en;
  logic [DW-1:0]     r_mm_rdata;
  logic              r_mm_wr_en;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DW-1:0]     r_wr_data;

  logic [BEAT_W-1:0] w_next_beat;
  logic [COL_W-1:0]  w_next_col;

  assign w_next_beat = r_beat + BEAT_W'(1);
  assign w_next_col  = r_col + COL_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_src      <= '0;
      r_dst      <= '0;
      r_beat     <= '0;
      r_col      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd_en    <= 1'b0;
      r_rd_addr  <= '0;
      r_mm_rd_en <= 1'b0;
      r_mm_rdata <= '0;
      r_mm_wr_en <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else begin
      // Strobes are single-cycle unless a transition below re-arms them.
      r_rd_en    <= 1'b0;
      r_mm_rd_en <= 1'b0;
      r_mm_wr_en <= 1'b0;
      r_done     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_seq.start) begin
            r_src     <= io_seq.src_base;
            r_dst     <= io_seq.dst_base;
            r_beat    <= '0;
            r_col     <= '0;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_rd_addr <= io_seq.src_base;
            r_state   <= S_RD_REQ;
          end
        end
        S_RD_REQ: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          if (io_seq.mem_rd_valid) begin
            r_mm_rdata <= io_seq.mem_rd_data;
            r_mm_rd_en <= 1'b1;
            if (r_beat == BEAT_W'(LOAD_BEATS - 1)) begin
              r_cnt   <= '0;
              r_state <= S_COMPUTE;
            end else begin
              r_beat    <= w_next_beat;
              r_rd_en   <= 1'b1;
              r_rd_addr <= r_src + ADDR_W'(w_next_beat);
              r_state   <= S_RD_REQ;
            end
          end
        end
        // The first COMPUTE cycle coincides with the final load strobe.
        S_COMPUTE: begin
          if (r_cnt == CNT_W'(MULT_LATENCY - 1)) begin
            r_col      <= '0;
            r_mm_wr_en <= 1'b1;
            r_state    <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_FETCH: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_wr_data <= io_seq.mm_res;
          r_wr_addr <= r_dst + ADDR_W'(r_col);
          r_wr_en   <= 1'b1;
          r_state   <= S_WR;
        end
        S_WR: begin
          if (io_seq.mem_wr_ack) begin
            r_wr_en <= 1'b0;
            if (r_col == COL_W'(MATRIX_WIDTH - 1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_col      <= w_next_col;
              r_mm_wr_en <= 1'b1;
              r_state    <= S_FETCH;
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_seq.busy        = r_busy;
  assign io_seq.done        = r_done;
  assign io_seq.mem_rd_en   = r_rd_en;
  assign io_seq.mem_rd_addr = r_rd_addr;
  assign io_seq.mm_read_en  = r_mm_rd_en;
  assign io_seq.mm_rdata    = r_mm_rdata;
  assign io_seq.mm_write_en = r_mm_wr_en;
  assign io_seq.mem_wr_en   = r_wr_en;
  assign io_seq.mem_wr_addr = r_wr_addr;
  assign io_seq.mem_wr_data = r_wr_data;

`ifdef MATMUL_SEQ_PERF_CNT_EN
  logic [31:0] r_perf;
  logic [31:0] r_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf  <= '0;
      r_stall <= '0;
    end else if (r_state == S_IDLE && io_seq.start) begin
      r_perf  <= '0;
      r_stall <= '0;
    end else begin
      if (r_busy) r_perf <= r_perf + 32'd1;
      if (r_state == S_RD_WAIT || (r_state == S_WR && !io_seq.mem_wr_ack))
        r_stall <= r_stall + 32'd1;
    end
  end

  assign perf_cycles  = r_perf;
  assign stall_cycles = r_stall;
`endif
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: randomized memory/datapath responders, expected traffic queued per run.
module tb_matmul_seq_ctrl;
  localparam int W  = 8;
  localparam int NE = 4;
  localparam int N  = 4;
  localparam int AW = 16;
  localparam int ML = 4;
  localparam int LB = N * N / 2;
  localparam int DW = NE * W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_seq_ctrl_if #(.WIDTH(W), .NUM_ELEMENTS(NE), .ADDR_W(AW)) bus();

  matmul_seq_ctrl #(
    .WIDTH(W), .NUM_ELEMENTS(NE), .MATRIX_WIDTH(N), .ADDR_W(AW), .MULT_LATENCY(ML)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io_seq(bus)
  );

  logic [DW-1:0] mem_arr [0:65535];
  logic [DW-1:0] res_vals [N];
  int            wr_delay [N];
  int            rd_delay = 1;
  int            res_idx = 0;
  int            wr_idx = 0;

  logic [AW-1:0] q_rd_addr [$];
  logic [DW-1:0] q_load [$];
  logic [AW-1:0] q_wr_addr [$];
  logic [DW-1:0] q_wr_data [$];

  int total = 0;
  int bad = 0;
  bit run_active = 0;
  int start_cyc = 0;
  int exp_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory and datapath responders; state is dropped whenever the sequencer is idle.
  initial begin
    int rd_cnt;
    logic [AW-1:0] rd_a;
    bit wr_act;
    int wr_left;
    bit res_pend;
    rd_cnt = 0; rd_a = '0; wr_act = 0; wr_left = 0; res_pend = 0;
    bus.mem_rd_valid = 1'b0;
    bus.mem_rd_data  = '0;
    bus.mem_wr_ack   = 1'b0;
    bus.mm_res       = '0;
    forever begin
      tick();
      bus.mem_rd_valid = 1'b0;
      bus.mem_rd_data  = $urandom;
      bus.mem_wr_ack   = 1'b0;
      if (!bus.busy) begin
        rd_cnt = 0; wr_act = 0; res_pend = 0;
        bus.mm_res = $urandom;
        if ($urandom_range(0, 3) == 0) bus.mem_rd_valid = 1'b1;
      end else begin
        if (res_pend && res_idx < N) begin
          bus.mm_res = res_vals[res_idx];
          res_idx++;
        end else begin
          bus.mm_res = $urandom;
        end
        res_pend = bus.mm_write_en;
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin
            bus.mem_rd_valid = 1'b1;
            bus.mem_rd_data  = mem_arr[rd_a];
          end
        end
        if (bus.mem_rd_en) begin
          rd_a   = bus.mem_rd_addr;
          rd_cnt = rd_delay;
        end
        if (bus.mem_wr_en) begin
          if (!wr_act) begin
            wr_act  = 1;
            wr_left = (wr_idx < N) ? wr_delay[wr_idx] : 0;
          end
          if (wr_left == 0) begin
            bus.mem_wr_ack = 1'b1;
            wr_act = 0;
            wr_idx++;
          end else begin
            wr_left--;
          end
        end
      end
    end
  end

  // Monitor: compares every presented output against the queued expectations.
  initial begin
    bit outst;
    bit exp_busy;
    outst = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        outst = 0;
        continue;
      end
      exp_busy = run_active && (cyc > start_cyc) && (cyc < exp_done);
      check("busy", bus.busy, exp_busy);
      check("done", bus.done, run_active && (cyc == exp_done));
      if (bus.mem_rd_valid) outst = 0;
      if (bus.mem_rd_en) begin
        check("rd_one_outstanding", outst, 0);
        outst = 1;
        if (q_rd_addr.size() == 0) check("rd_unexpected", bus.mem_rd_en, 0);
        else check("rd_addr", bus.mem_rd_addr, q_rd_addr.pop_front());
      end
      if (bus.mm_read_en) begin
        if (q_load.size() == 0) check("load_unexpected", bus.mm_read_en, 0);
        else check("load_data", bus.mm_rdata, q_load.pop_front());
      end
      if (bus.mem_wr_en) begin
        check("fetch_during_wr", bus.mm_write_en, 0);
        if (q_wr_addr.size() == 0) check("wr_unexpected", bus.mem_wr_en, 0);
        else begin
          check("wr_addr", bus.mem_wr_addr, q_wr_addr[0]);
          check("wr_data", bus.mem_wr_data, q_wr_data[0]);
          if (bus.mem_wr_ack) begin
            void'(q_wr_addr.pop_front());
            void'(q_wr_data.pop_front());
          end
        end
      end
      if (run_active && cyc == exp_done) begin
        check("rd_left", q_rd_addr.size(), 0);
        check("load_left", q_load.size(), 0);
        check("wr_left", q_wr_addr.size(), 0);
        check("fetch_count", res_idx, N);
        run_active = 0;
      end
    end
  end

  // Reference: reads src+k, loads mem[src+k], writes res[c] to dst+c; run length from per-step costs.
  task automatic run_start(input logic [AW-1:0] src, input logic [AW-1:0] dst, input int d,
                           input int w0, input int w1, input int w2, input int w3);
    int sum;
    logic [AW-1:0] a;
    rd_delay = d;
    wr_delay[0] = w0; wr_delay[1] = w1; wr_delay[2] = w2; wr_delay[3] = w3;
    res_idx = 0;
    wr_idx  = 0;
    sum = 0;
    for (int k = 0; k < LB; k++) begin
      a = src + AW'(k);
      q_rd_addr.push_back(a);
      q_load.push_back(mem_arr[a]);
    end
    for (int c = 0; c < N; c++) begin
      res_vals[c] = $urandom;
      a = dst + AW'(c);
      q_wr_addr.push_back(a);
      q_wr_data.push_back(res_vals[c]);
      sum += 3 + wr_delay[c];
    end
    bus.src_base = src;
    bus.dst_base = dst;
    bus.start    = 1'b1;
    start_cyc    = cyc;
    exp_done     = cyc + LB * (1 + d) + ML + sum + 1;
    run_active   = 1;
    tick();
    bus.start    = 1'b0;
    bus.src_base = $urandom;
    bus.dst_base = $urandom;
  endtask

  task automatic wait_done();
    int lim;
    lim = exp_done + 3;
    while (cyc <= lim) tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.src_base = '0;
    bus.dst_base = '0;
    for (int i = 0; i < 65536; i++) mem_arr[i] = $urandom;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rd_en", bus.mem_rd_en, 0);
    check("rst_wr_en", bus.mem_wr_en, 0);
    check("rst_mm_read_en", bus.mm_read_en, 0);
    check("rst_mm_write_en", bus.mm_write_en, 0);
    tick();

    // Zero-wait baseline: 33 cycles start to done.
    run_start(16'h0100, 16'h0200, 1, 0, 0, 0, 0);
    wait_done();
    // Slow reads: 49 cycles.
    run_start(16'h0120, 16'h0220, 3, 0, 0, 0, 0);
    wait_done();
    // Column 2 ack withheld for 5 cycles.
    run_start(16'h0100, 16'h0200, 1, 0, 0, 5, 0);
    wait_done();

    // Stray starts during load and in DONE, then a back-to-back run.
    run_start(16'h0300, 16'h0400, 1, 0, 1, 0, 2);
    repeat (5) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (cyc < exp_done) tick();
    bus.start = 1'b1;
    tick();
    run_start(16'h0310, 16'h0410, 2, 0, 0, 0, 0);
    wait_done();

    // Reset in COMPUTE aborts, then a clean run.
    run_start(16'h0500, 16'h0600, 1, 0, 0, 0, 0);
    while (cyc < start_cyc + 18) tick();
    reset = 1'b1;
    run_active = 0;
    q_rd_addr.delete();
    q_load.delete();
    q_wr_addr.delete();
    q_wr_data.delete();
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_rd_en", bus.mem_rd_en, 0);
    check("abort_rd_addr", bus.mem_rd_addr, 0);
    check("abort_mm_read_en", bus.mm_read_en, 0);
    check("abort_mm_rdata", bus.mm_rdata, 0);
    check("abort_mm_write_en", bus.mm_write_en, 0);
    check("abort_wr_en", bus.mem_wr_en, 0);
    check("abort_wr_addr", bus.mem_wr_addr, 0);
    check("abort_wr_data", bus.mem_wr_data, 0);
    tick();
    run_start(16'h0500, 16'h0600, 1, 0, 0, 0, 0);
    wait_done();

    // Source address wrap.
    run_start(16'hFFFE, 16'h0700, 1, 0, 0, 0, 0);
    wait_done();
    // Destination wrap with slow memory.
    run_start(16'h0800, 16'hFFFE, 2, 1, 0, 3, 0);
    wait_done();

    for (int r = 0; r < 6; r++) begin
      run_start(16'($urandom), 16'($urandom), $urandom_range(1, 4),
                $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), $urandom_range(0, 3));
      wait_done();
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
